uc_multiciclo: RTL and testbench
================================

UC_MULTICICLO -- requirements
Module: uc_multiciclo

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1, meaning: 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 Parameter BRANCH_EXT, default 0, meaning: 0 = branch opcode decoded as beq only; 1 = beq/bne/blt/bge by f3.
REQ-003 Parameter CNT_W, default 32, meaning: width of retired-instruction counter.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 op  input  7  opcode; f3  input  3  funct3; f7  input  7  funct7.
REQ-007 zero  input  1  ALU result == 0; lt  input  1  ALU signed less-than flag.
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 pcWrite, adrSrc, memWrite, irWrite, regWrite  output  1 each  PC load, address mux select (0=PC, 1=ALUOut), memory write, IR load, register-file write.
REQ-010 resultSrc, aluSrcA, aluSrcB, immSrc  output  2 each  datapath mux selects / immediate format.
REQ-011 aluControl  output  3  ALU operation.
REQ-012 state  output  4  current FSM state (debug); illegal  output  1  trap flag; instr_done  output  1  retire pulse; instret  output  CNT_W  retired count.

Function
REQ-013 FSM SHALL use encoding FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BRANCH=10, TRAP=11; codes 12-15 SHALL go to TRAP.
REQ-014 Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, branch 1100011, jal 1101111; any other opcode in DECODE -> TRAP.
REQ-015 Transitions: FETCH->DECODE when ready; DECODE-> MEMADR (lw/sw), EXECUTER (R), EXECUTEI (I), JAL, BRANCH; MEMADR->MEMREAD (lw) / MEMWRITE (sw); MEMREAD->MEMWB when ready; MEMWRITE->FETCH when ready; EXECUTER/EXECUTEI->ALUWB; JAL->ALUWB; ALUWB, MEMWB, BRANCH->FETCH; TRAP holds until reset.
REQ-016 "ready" = mem_ready when MEM_HANDSHAKE=1, constant 1 otherwise; while not ready the FSM stays in its state with outputs unchanged.
REQ-017 Per-state outputs (unlisted = 0): FETCH aluSrcB=10, resultSrc=10, irWrite=pcWrite=ready; DECODE aluSrcA=01, aluSrcB=01; MEMADR aluSrcA=10, aluSrcB=01; MEMREAD adrSrc=1; MEMWB resultSrc=01, regWrite=1; MEMWRITE adrSrc=1, memWrite=1; EXECUTER aluSrcA=10, aluOp=10; EXECUTEI aluSrcA=10, aluSrcB=01, aluOp=10; ALUWB regWrite=1; JAL aluSrcA=01, aluSrcB=10, pcWrite=1; BRANCH aluSrcA=10, aluOp=01, pcWrite=taken.
REQ-018 memWrite SHALL stay asserted for every MEMWRITE cycle including wait cycles.
REQ-019 taken: BRANCH_EXT=0 -> zero; BRANCH_EXT=1 -> f3 000 zero, 001 !zero, 100 lt, 101 !lt, other 0.
REQ-020 immSrc from op combinationally: lw/I 00, sw 01, branch 10, jal 11, other 00.
REQ-021 aluControl: aluOp 00->000 (add); 01->001 (sub); 10 by f3: 000 -> 001 if op[5]&f7[5] else 000; 010->101; 110->011; 111->010; other 000.
REQ-022 illegal SHALL be 1 exactly while state==TRAP; all write enables 0 in TRAP.
REQ-023 instr_done SHALL be 1 in the last cycle of an instruction: ALUWB, MEMWB, BRANCH, MEMWRITE with ready.
REQ-024 instret SHALL increment by 1 on each clock edge where instr_done=1, wrapping from 2^CNT_W-1 to 0.

Reset
REQ-025 Edge with rst_n=0: state<=FETCH, instret<=0, regardless of current state (incl. mid-wait, TRAP).
REQ-026 While rst_n=0, pcWrite, irWrite, memWrite, regWrite, instr_done SHALL be forced 0.

Verification
REQ-027 add (op 0110011, f3 000, f7 0) with MEM_HANDSHAKE=0 -> states 0,1,6,7,0; aluControl 000 in EXECUTER; regWrite=1 only in ALUWB; instret +1.
REQ-028 lw with mem_ready low 3 cycles in MEMREAD -> state 3 held 4 cycles, then MEMWB with resultSrc=01; total 5+3 cycles.
REQ-029 BRANCH_EXT=1, bne (f3 001), zero=0 -> pcWrite=1 in BRANCH; zero=1 -> pcWrite=0; BRANCH_EXT=0 same bne, zero=1 -> pcWrite=1.
REQ-030 op 1111111 -> TRAP after DECODE; illegal=1, no writes for 10 cycles; rst_n=0 one edge -> state 0, illegal=0.
REQ-031 CNT_W=4, 16 retired instructions -> instret wraps to 0.
REQ-032 rst_n=0 during MEMWRITE wait -> memWrite 0 same cycle, state 0 next edge, instret 0.

Source files
------------

// File: rtl/uc_multiciclo.sv
// ---------------------------------------------------------------------------
// uc_multiciclo -- control unit for a multicycle RISC-V style datapath.
//
// A twelve-state FSM sequences each instruction through fetch, decode and
// the execute/memory/write-back steps, driving the datapath mux selects,
// write enables and the ALU operation code. Unknown opcodes trap until reset.
// Retired instructions are counted in a wrapping counter.
//
// Parameters
//   MEM_HANDSHAKE  1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: ignore it
//   BRANCH_EXT     0: branch = beq only; 1: beq/bne/blt/bge selected by f3
//   CNT_W          width of the retired-instruction counter
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   op, f3, f7                  opcode / funct3 / funct7 of the current IR
//   zero, lt                    ALU flags (result == 0, signed less-than)
//   mem_ready                   memory access completes this cycle
//   pcWrite, adrSrc, memWrite,
//   irWrite, regWrite           enables and address select (0=PC, 1=ALUOut)
//   resultSrc, aluSrcA,
//   aluSrcB, immSrc             datapath mux selects / immediate format
//   aluControl                  ALU operation
//   state                       current FSM state (debug)
//   illegal                     high while trapped on an unknown opcode
//   instr_done, instret         retire pulse and retired-instruction count
// ---------------------------------------------------------------------------
module uc_multiciclo #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int BRANCH_EXT    = 0,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       f3,
    input  logic [6:0]       f7,
    input  logic             zero,
    input  logic             lt,
    input  logic             mem_ready,
    output logic             pcWrite,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             irWrite,
    output logic             regWrite,
    output logic [1:0]       resultSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       immSrc,
    output logic [2:0]       aluControl,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] EXECUTEI = 4'd8;
    localparam logic [3:0] JAL      = 4'd9;
    localparam logic [3:0] BRANCH   = 4'd10;
    localparam logic [3:0] TRAP     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0]       stateR;
    logic [3:0]       nextStateS;
    logic [CNT_W-1:0] instretR;
    logic             readyS;
    logic             takenS;
    logic [1:0]       aluOpS;
    logic             pcWriteS;
    logic             memWriteS;
    logic             irWriteS;
    logic             regWriteS;
    logic             doneS;
    logic             unusedF7S;

    // Only f7[5] distinguishes add/sub; the remaining funct7 bits are don't-care.
    assign unusedF7S = ^{f7[6], f7[4:0]};

    // With the handshake disabled every memory access completes in one cycle.
    assign readyS = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    // State register; reset wins over any state, including waits and TRAP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateR <= FETCH;
        end else begin
            stateR <= nextStateS;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instretR <= '0;
        end else if (doneS) begin
            instretR <= instretR + CNT_W'(1);
        end else begin
            instretR <= instretR;
        end
    end

    // Next-state logic; unused codes 12-15 fall into TRAP.
    always_comb begin
        nextStateS = stateR;
        case (stateR)
            FETCH:    nextStateS = readyS ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: nextStateS = MEMADR;
                    OP_R:         nextStateS = EXECUTER;
                    OP_I:         nextStateS = EXECUTEI;
                    OP_JAL:       nextStateS = JAL;
                    OP_BR:        nextStateS = BRANCH;
                    default:      nextStateS = TRAP;
                endcase
            end
            MEMADR:   nextStateS = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  nextStateS = readyS ? MEMWB : MEMREAD;
            MEMWB:    nextStateS = FETCH;
            MEMWRITE: nextStateS = readyS ? FETCH : MEMWRITE;
            EXECUTER: nextStateS = ALUWB;
            EXECUTEI: nextStateS = ALUWB;
            ALUWB:    nextStateS = FETCH;
            JAL:      nextStateS = ALUWB;
            BRANCH:   nextStateS = FETCH;
            TRAP:     nextStateS = TRAP;
            default:  nextStateS = TRAP;
        endcase
    end

    // Branch condition; the extended set is selected by funct3.
    always_comb begin
        takenS = 1'b0;
        if (BRANCH_EXT != 0) begin
            case (f3)
                3'b000:  takenS = zero;
                3'b001:  takenS = ~zero;
                3'b100:  takenS = lt;
                3'b101:  takenS = ~lt;
                default: takenS = 1'b0;
            endcase
        end else begin
            takenS = zero;
        end
    end

    // Per-state control outputs; anything not set stays 0 (incl. TRAP).
    always_comb begin
        pcWriteS  = 1'b0;
        adrSrc    = 1'b0;
        memWriteS = 1'b0;
        irWriteS  = 1'b0;
        regWriteS = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        aluOpS    = 2'b00;
        doneS     = 1'b0;
        case (stateR)
            FETCH: begin
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                irWriteS  = readyS;
                pcWriteS  = readyS;
            end
            DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
            end
            MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            MEMREAD:  adrSrc = 1'b1;
            MEMWB: begin
                resultSrc = 2'b01;
                regWriteS = 1'b1;
                doneS     = 1'b1;
            end
            MEMWRITE: begin
                // Held through wait cycles; the store retires when memory is ready.
                adrSrc    = 1'b1;
                memWriteS = 1'b1;
                doneS     = readyS;
            end
            EXECUTER: begin
                aluSrcA = 2'b10;
                aluOpS  = 2'b10;
            end
            EXECUTEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                aluOpS  = 2'b10;
            end
            ALUWB: begin
                regWriteS = 1'b1;
                doneS     = 1'b1;
            end
            JAL: begin
                aluSrcA  = 2'b01;
                aluSrcB  = 2'b10;
                pcWriteS = 1'b1;
            end
            BRANCH: begin
                aluSrcA  = 2'b10;
                aluOpS   = 2'b01;
                pcWriteS = takenS;
                doneS    = 1'b1;
            end
            default: doneS = 1'b0;
        endcase
    end

    // ALU decoder; sub only for R-type (op[5]) with funct7[5] set.
    always_comb begin
        aluControl = 3'b000;
        case (aluOpS)
            2'b00: aluControl = 3'b000;
            2'b01: aluControl = 3'b001;
            2'b10: begin
                case (f3)
                    3'b000:  aluControl = (op[5] & f7[5]) ? 3'b001 : 3'b000;
                    3'b010:  aluControl = 3'b101;
                    3'b110:  aluControl = 3'b011;
                    3'b111:  aluControl = 3'b010;
                    default: aluControl = 3'b000;
                endcase
            end
            default: aluControl = 3'b000;
        endcase
    end

    // Immediate format straight from the opcode.
    always_comb begin
        case (op)
            OP_LW, OP_I: immSrc = 2'b00;
            OP_SW:       immSrc = 2'b01;
            OP_BR:       immSrc = 2'b10;
            OP_JAL:      immSrc = 2'b11;
            default:     immSrc = 2'b00;
        endcase
    end

    // Write enables and the retire pulse are suppressed while reset is held.
    assign pcWrite    = pcWriteS & rst_n;
    assign irWrite    = irWriteS & rst_n;
    assign memWrite   = memWriteS & rst_n;
    assign regWrite   = regWriteS & rst_n;
    assign instr_done = doneS & rst_n;
    assign illegal    = (stateR == TRAP);
    assign state      = stateR;
    assign instret    = instretR;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo. Instance dut: handshake on, extended
// branches, 4-bit counter. Instance dut0: handshake off (mem_ready tied low),
// beq-only branches, 32-bit counter.
module tb_uc_multiciclo;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_ILL = 7'b1111111;

    // ctl = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc, aluSrcA, aluSrcB}
    localparam logic [12:0] C_FETCH    = 13'b1_0_0_1_0_10_00_10;
    localparam logic [12:0] C_FETCHW   = 13'b0_0_0_0_0_10_00_10;
    localparam logic [12:0] C_DECODE   = 13'b0_0_0_0_0_00_01_01;
    localparam logic [12:0] C_MEMADR   = 13'b0_0_0_0_0_00_10_01;
    localparam logic [12:0] C_MEMREAD  = 13'b0_1_0_0_0_00_00_00;
    localparam logic [12:0] C_MEMWB    = 13'b0_0_0_0_1_01_00_00;
    localparam logic [12:0] C_MEMWRITE = 13'b0_1_1_0_0_00_00_00;
    localparam logic [12:0] C_EXECR    = 13'b0_0_0_0_0_00_10_00;
    localparam logic [12:0] C_EXECI    = 13'b0_0_0_0_0_00_10_01;
    localparam logic [12:0] C_ALUWB    = 13'b0_0_0_0_1_00_00_00;
    localparam logic [12:0] C_JAL      = 13'b1_0_0_0_0_00_01_10;
    localparam logic [12:0] C_BRT      = 13'b1_0_0_0_0_00_10_00;
    localparam logic [12:0] C_BRN      = 13'b0_0_0_0_0_00_10_00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN, rstN0, memReady, zero, lt;
    logic       memReady0 = 1'b0;
    logic [6:0] op, f7;
    logic [2:0] f3;

    logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal, instr_done;
    logic [1:0]  resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0]  aluControl;
    logic [3:0]  state;
    logic [3:0]  instret;
    logic        pcWrite0, adrSrc0, memWrite0, irWrite0, regWrite0, illegal0, instr_done0;
    logic [1:0]  resultSrc0, aluSrcA0, aluSrcB0, immSrc0;
    logic [2:0]  aluControl0;
    logic [3:0]  state0;
    logic [31:0] instret0;

    logic [12:0] ctl, ctl0;
    assign ctl  = {pcWrite, adrSrc, memWrite, irWrite, regWrite, resultSrc, aluSrcA, aluSrcB};
    assign ctl0 = {pcWrite0, adrSrc0, memWrite0, irWrite0, regWrite0, resultSrc0, aluSrcA0, aluSrcB0};

    int nTests = 0;
    int nFail  = 0;

    uc_multiciclo #(.MEM_HANDSHAKE(1), .BRANCH_EXT(1), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rstN), .op(op), .f3(f3), .f7(f7), .zero(zero), .lt(lt),
        .mem_ready(memReady), .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite),
        .irWrite(irWrite), .regWrite(regWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .immSrc(immSrc), .aluControl(aluControl), .state(state),
        .illegal(illegal), .instr_done(instr_done), .instret(instret)
    );

    uc_multiciclo #(.MEM_HANDSHAKE(0), .BRANCH_EXT(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rstN0), .op(op), .f3(f3), .f7(f7), .zero(zero), .lt(lt),
        .mem_ready(memReady0), .pcWrite(pcWrite0), .adrSrc(adrSrc0), .memWrite(memWrite0),
        .irWrite(irWrite0), .regWrite(regWrite0), .resultSrc(resultSrc0), .aluSrcA(aluSrcA0),
        .aluSrcB(aluSrcB0), .immSrc(immSrc0), .aluControl(aluControl0), .state(state0),
        .illegal(illegal0), .instr_done(instr_done0), .instret(instret0)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rstN = 1'b0;
        cyc();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; memReady = 1'b1; op = OP_R; f3 = 3'b000; f7 = 7'd0;
        cyc();
        nTests++;
        if ({state, instret, ctl, instr_done, illegal} !== {4'd0, 4'd0, C_FETCHW, 1'b0, 1'b0}) begin
            nFail++;
            $display("FAIL reset_hold: got state=%0d instret=%0d ctl=%b done=%b ill=%b, expected state=0 instret=0 ctl=%b done=0 ill=0",
                     state, instret, ctl, instr_done, illegal, C_FETCHW);
        end
        rstN = 1'b1;
        #1;
        nTests++;
        if (ctl !== C_FETCH) begin
            nFail++;
            $display("FAIL reset_release_fetch: got ctl=%b expected %b", ctl, C_FETCH);
        end
    endtask

    task automatic test_alu_nohandshake();
        logic [6:0] opv [6] = '{OP_R, OP_R, OP_I, OP_R, OP_R, OP_R};
        logic [2:0] f3v [6] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b110, 3'b001};
        logic [6:0] f7v [6] = '{7'h00, 7'h20, 7'h20, 7'h00, 7'h00, 7'h00};
        logic [2:0] acv [6] = '{3'b000, 3'b001, 3'b000, 3'b101, 3'b011, 3'b000};
        logic [3:0]  st [4];
        logic [12:0] cv [4];
        rstN0 = 1'b0;
        cyc();
        rstN0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            op = opv[k]; f3 = f3v[k]; f7 = f7v[k];
            st = '{4'd0, 4'd1, (opv[k] == OP_I) ? 4'd8 : 4'd6, 4'd7};
            cv = '{C_FETCH, C_DECODE, (opv[k] == OP_I) ? C_EXECI : C_EXECR, C_ALUWB};
            for (int i = 0; i < 4; i++) begin
                #1;
                nTests++;
                if ({state0, ctl0, instr_done0} !== {st[i], cv[i], (i == 3)}) begin
                    nFail++;
                    $display("FAIL alu%0d_cycle%0d: got state=%0d ctl=%b done=%b, expected state=%0d ctl=%b done=%b",
                             k, i, state0, ctl0, instr_done0, st[i], cv[i], (i == 3));
                end
                if (i == 2) begin
                    nTests++;
                    if (aluControl0 !== acv[k]) begin
                        nFail++;
                        $display("FAIL alu%0d_aluControl: got %b expected %b", k, aluControl0, acv[k]);
                    end
                end
                cyc();
            end
            nTests++;
            if ({state0, instret0} !== {4'd0, 32'(k + 1)}) begin
                nFail++;
                $display("FAIL alu%0d_retire: got state=%0d instret=%0d expected state=0 instret=%0d",
                         k, state0, instret0, k + 1);
            end
        end
        rstN0 = 1'b0;
    endtask

    task automatic test_lw_wait();
        logic        rdy [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  st  [9] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
        logic [12:0] cv  [9] = '{C_FETCHW, C_FETCH, C_DECODE, C_MEMADR, C_MEMREAD,
                                 C_MEMREAD, C_MEMREAD, C_MEMREAD, C_MEMWB};
        resetDut();
        op = OP_LW;
        for (int i = 0; i < 9; i++) begin
            memReady = rdy[i];
            #1;
            nTests++;
            if ({state, ctl, instr_done, immSrc} !== {st[i], cv[i], (i == 8), 2'b00}) begin
                nFail++;
                $display("FAIL lw_cycle%0d: got state=%0d ctl=%b done=%b imm=%b, expected state=%0d ctl=%b done=%b imm=00",
                         i, state, ctl, instr_done, immSrc, st[i], cv[i], (i == 8));
            end
            cyc();
        end
        nTests++;
        if ({state, instret} !== {4'd0, 4'd1}) begin
            nFail++;
            $display("FAIL lw_retire: got state=%0d instret=%0d expected state=0 instret=1", state, instret);
        end
    endtask

    task automatic test_sw_reset_in_wait();
        logic        rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0]  st  [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5};
        logic [12:0] cv  [6] = '{C_FETCH, C_DECODE, C_MEMADR, C_MEMWRITE, C_MEMWRITE, C_MEMWRITE};
        resetDut();
        op = OP_SW;
        for (int i = 0; i < 6; i++) begin
            memReady = rdy[i];
            #1;
            nTests++;
            if ({state, ctl, instr_done, immSrc} !== {st[i], cv[i], (i == 5), 2'b01}) begin
                nFail++;
                $display("FAIL sw_cycle%0d: got state=%0d ctl=%b done=%b imm=%b, expected state=%0d ctl=%b done=%b imm=01",
                         i, state, ctl, instr_done, immSrc, st[i], cv[i], (i == 5));
            end
            cyc();
        end
        nTests++;
        if ({state, instret} !== {4'd0, 4'd1}) begin
            nFail++;
            $display("FAIL sw_retire: got state=%0d instret=%0d expected state=0 instret=1", state, instret);
        end
        memReady = 1'b1;
        repeat (3) cyc();
        memReady = 1'b0;
        repeat (2) cyc();
        nTests++;
        if ({state, memWrite} !== {4'd5, 1'b1}) begin
            nFail++;
            $display("FAIL sw_wait_hold: got state=%0d memWrite=%b expected state=5 memWrite=1", state, memWrite);
        end
        rstN = 1'b0;
        #1;
        nTests++;
        if ({state, memWrite, instr_done, pcWrite, irWrite, regWrite} !== {4'd5, 5'b00000}) begin
            nFail++;
            $display("FAIL sw_reset_same_cycle: got state=%0d memWrite=%b done=%b pc=%b ir=%b reg=%b expected state=5 all 0",
                     state, memWrite, instr_done, pcWrite, irWrite, regWrite);
        end
        cyc();
        nTests++;
        if ({state, instret} !== {4'd0, 4'd0}) begin
            nFail++;
            $display("FAIL sw_reset_next_edge: got state=%0d instret=%0d expected state=0 instret=0", state, instret);
        end
        rstN = 1'b1;
    endtask

    task automatic test_branch();
        logic [2:0] f3v [7] = '{3'b001, 3'b001, 3'b000, 3'b100, 3'b101, 3'b101, 3'b010};
        logic       zv  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       lv  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       tk  [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        resetDut();
        op = OP_BR; memReady = 1'b1;
        for (int k = 0; k < 7; k++) begin
            f3 = f3v[k]; zero = zv[k]; lt = lv[k];
            repeat (2) cyc();
            nTests++;
            if ({state, ctl, aluControl, immSrc, instr_done} !== {4'd10, tk[k] ? C_BRT : C_BRN, 3'b001, 2'b10, 1'b1}) begin
                nFail++;
                $display("FAIL branch%0d: got state=%0d ctl=%b alu=%b imm=%b done=%b, expected state=10 ctl=%b alu=001 imm=10 done=1",
                         k, state, ctl, aluControl, immSrc, instr_done, tk[k] ? C_BRT : C_BRN);
            end
            cyc();
        end
        nTests++;
        if ({state, instret} !== {4'd0, 4'd7}) begin
            nFail++;
            $display("FAIL branch_retire: got state=%0d instret=%0d expected state=0 instret=7", state, instret);
        end
        // beq-only instance: f3 ignored, pcWrite follows zero.
        rstN0 = 1'b0;
        cyc();
        rstN0 = 1'b1;
        f3 = 3'b001;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            repeat (2) cyc();
            nTests++;
            if ({state0, pcWrite0} !== {4'd10, (k == 0)}) begin
                nFail++;
                $display("FAIL beq_only%0d: got state=%0d pcWrite=%b expected state=10 pcWrite=%b",
                         k, state0, pcWrite0, (k == 0));
            end
            cyc();
        end
        rstN0 = 1'b0;
    endtask

    task automatic test_jal();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd9, 4'd7};
        logic [12:0] cv [4] = '{C_FETCH, C_DECODE, C_JAL, C_ALUWB};
        resetDut();
        op = OP_JAL; memReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            nTests++;
            if ({state, ctl, instr_done, immSrc} !== {st[i], cv[i], (i == 3), 2'b11}) begin
                nFail++;
                $display("FAIL jal_cycle%0d: got state=%0d ctl=%b done=%b imm=%b, expected state=%0d ctl=%b done=%b imm=11",
                         i, state, ctl, instr_done, immSrc, st[i], cv[i], (i == 3));
            end
            cyc();
        end
    endtask

    task automatic test_trap();
        resetDut();
        op = OP_ILL; memReady = 1'b1;
        cyc();
        nTests++;
        if ({state, ctl} !== {4'd1, C_DECODE}) begin
            nFail++;
            $display("FAIL trap_decode: got state=%0d ctl=%b expected state=1 ctl=%b", state, ctl, C_DECODE);
        end
        cyc();
        for (int i = 0; i < 10; i++) begin
            memReady = i[0];
            op = (i > 5) ? OP_R : OP_ILL;
            #1;
            nTests++;
            if ({state, illegal, ctl, instr_done, instret} !== {4'd11, 1'b1, 13'd0, 1'b0, 4'd0}) begin
                nFail++;
                $display("FAIL trap_hold%0d: got state=%0d ill=%b ctl=%b done=%b instret=%0d, expected state=11 ill=1 ctl=0 done=0 instret=0",
                         i, state, illegal, ctl, instr_done, instret);
            end
            cyc();
        end
        rstN = 1'b0;
        cyc();
        nTests++;
        if ({state, illegal} !== {4'd0, 1'b0}) begin
            nFail++;
            $display("FAIL trap_reset: got state=%0d ill=%b expected state=0 ill=0", state, illegal);
        end
        rstN = 1'b1;
    endtask

    task automatic test_back_to_back_wrap();
        logic [3:0] expCnt = 4'd0;
        resetDut();
        op = OP_R; f3 = 3'b000; f7 = 7'd0; memReady = 1'b1;
        for (int k = 0; k < 16; k++) begin
            repeat (4) cyc();
            expCnt = expCnt + 4'd1;
            nTests++;
            if ({state, instret} !== {4'd0, expCnt}) begin
                nFail++;
                $display("FAIL wrap%0d: got state=%0d instret=%0d expected state=0 instret=%0d",
                         k, state, instret, expCnt);
            end
        end
    endtask

    initial begin
        rstN = 1'b0; rstN0 = 1'b0; memReady = 1'b1; zero = 1'b0; lt = 1'b0;
        op = OP_R; f3 = 3'b000; f7 = 7'd0;
        repeat (2) cyc();
        test_reset();
        test_alu_nohandshake();
        test_lw_wait();
        test_sw_reset_in_wait();
        test_branch();
        test_jal();
        test_trap();
        test_back_to_back_wrap();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
